// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered single-port RAM between a CPU port and a
// DMA/loader port. A fixed IDLE->ISSUE->WAIT->ACK sequence serves one access
// per four cycles, with round-robin tie-breaking between the two requesters.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_dma
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_last_grant;
  logic              r_grant_dma;
  logic              r_we;
  logic              r_ram_w_en;
  logic              r_cpu_ack;
  logic              r_dma_ack;
  logic              r_busy;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_last_grant;
  logic              w_grant_dma;
  logic              w_we;
  logic              w_ram_w_en;
  logic              w_cpu_ack;
  logic              w_dma_ack;
  logic              w_busy;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_cpu_rdata;
  logic [DATA_W-1:0] w_dma_rdata;

  logic              w_any;
  logic              w_pick_dma;
  logic              w_pick_we;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_wdata;

  // Winner selection: a lone requester wins; on a tie the port that did not
  // win last time is chosen.
  assign w_any        = cpu_req | dma_req;
  assign w_pick_dma   = (cpu_req & dma_req) ? ~r_last_grant : dma_req;
  assign w_pick_we    = w_pick_dma ? dma_we    : cpu_we;
  assign w_pick_addr  = w_pick_dma ? dma_addr  : cpu_addr;
  assign w_pick_wdata = w_pick_dma ? dma_wdata : cpu_wdata;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_grant = r_last_grant;
    w_grant_dma  = r_grant_dma;
    w_we         = r_we;
    w_ram_addr   = r_ram_addr;
    w_ram_wdata  = r_ram_wdata;
    w_ram_w_en   = 1'b0;
    w_cpu_ack    = 1'b0;
    w_dma_ack    = 1'b0;
    w_cpu_rdata  = r_cpu_rdata;
    w_dma_rdata  = r_dma_rdata;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt  = ST_ISSUE;
          w_grant_dma  = w_pick_dma;
          w_last_grant = w_pick_dma;
          w_we         = w_pick_we;
          w_ram_addr   = w_pick_addr;
          w_ram_wdata  = w_pick_wdata;
          w_ram_w_en   = w_pick_we;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_state_nxt = ST_ACK;
        w_cpu_ack   = ~r_grant_dma;
        w_dma_ack   = r_grant_dma;
        if (!r_we) begin
          if (r_grant_dma) begin
            w_dma_rdata = ram_rdata;
          end else begin
            w_cpu_rdata = ram_rdata;
          end
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy = (w_state_nxt != ST_IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant_dma  <= 1'b0;
      r_we         <= 1'b0;
      r_ram_w_en   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_busy       <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_last_grant <= w_last_grant;
      r_grant_dma  <= w_grant_dma;
      r_we         <= w_we;
      r_ram_w_en   <= w_ram_w_en;
      r_cpu_ack    <= w_cpu_ack;
      r_dma_ack    <= w_dma_ack;
      r_busy       <= w_busy;
      r_ram_addr   <= w_ram_addr;
      r_ram_wdata  <= w_ram_wdata;
      r_cpu_rdata  <= w_cpu_rdata;
      r_dma_rdata  <= w_dma_rdata;
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_w_en  = r_ram_w_en;
  assign busy      = r_busy;
  assign grant_dma = r_grant_dma;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: registered RAM model, transaction-level reference
// model checked every cycle, directed vectors and randomized requesters.
module tb_ram_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, ram_wdata, ram_rdata;
  logic          cpu_ack, dma_ack, ram_w_en, busy, grant_dma;
  logic [DW-1:0] cpu_rdata, dma_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en),
    .ram_rdata(ram_rdata), .busy(busy), .grant_dma(grant_dma)
  );

  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  int cyc, errors, checks;

  // Reference model: one transaction in flight, described by when it was
  // selected and what it carries.
  int            t_sel, free_at;
  logic          t_dma, t_we, lg_m, e_ackc, e_ackd;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdval, m_crd, m_drd;

  typedef struct packed {
    logic          dma;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] crd;
    logic [DW-1:0] drd;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: registered RAM with write-through-free read of the old word.
  task automatic tick();
    @(posedge clk);
    if (ram_w_en) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    t_sel = -100; t_dma = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    lg_m = 1'b1; m_crd = '0; m_drd = '0; free_at = cyc + 1;
  endtask

  task automatic model_sample();
    if (rst) begin
      model_reset();
    end else if (cyc >= free_at && (cpu_req || dma_req)) begin
      if (cpu_req && dma_req) t_dma = ~lg_m;
      else                    t_dma = dma_req;
      lg_m    = t_dma;
      t_sel   = cyc;
      free_at = cyc + 4;
      t_we    = t_dma ? dma_we    : cpu_we;
      t_addr  = t_dma ? dma_addr  : cpu_addr;
      t_wdata = t_dma ? dma_wdata : cpu_wdata;
      if (t_we) shadow[t_addr] = t_wdata;
      else      t_rdval = shadow[t_addr];
    end
  endtask

  task automatic check_cycle();
    logic act;
    act    = (cyc == t_sel + 3);
    e_ackc = act && !t_dma;
    e_ackd = act && t_dma;
    if (act && !t_we) begin
      if (t_dma) m_drd = t_rdval;
      else       m_crd = t_rdval;
    end
    chk("cpu_ack",   32'(cpu_ack),   32'(e_ackc));
    chk("dma_ack",   32'(dma_ack),   32'(e_ackd));
    chk("busy",      32'(busy),      32'((cyc > t_sel) && (cyc <= t_sel + 3)));
    chk("ram_w_en",  32'(ram_w_en),  32'((cyc == t_sel + 1) && t_we));
    chk("grant_dma", 32'(grant_dma), 32'(t_dma));
    chk("ram_addr",  32'(ram_addr),  32'(t_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(t_wdata));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
    chk("dma_rdata", 32'(dma_rdata), 32'(m_drd));
  endtask

  task automatic step();
    model_sample();
    tick();
    check_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic new_pay(input logic is_dma);
    if (is_dma) begin
      dma_we = 1'($urandom_range(1)); dma_addr = AW'($urandom_range(15));
      dma_wdata = DW'($urandom);
    end else begin
      cpu_we = 1'($urandom_range(1)); cpu_addr = AW'($urandom_range(15));
      cpu_wdata = DW'($urandom);
    end
  endtask

  // Single directed transaction with hand-derived expected rdata values.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    logic got;
    lat = 0; got = 1'b0;
    if (v.dma) begin dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata; end
    else       begin cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; end
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      lat++;
      got = v.dma ? dma_ack : cpu_ack;
    end
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_cpu_rdata"}, 32'(cpu_rdata), 32'(v.crd));
    chk({name, "_dma_rdata"}, 32'(dma_rdata), 32'(v.drd));
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
  endtask

  // Both ports request in the same cycle; CPU must win and DMA follow 4 later.
  task automatic sim_pair(input string name, input logic [DW-1:0] exp_c,
                          input logic [DW-1:0] exp_d);
    int ca, da, t0, fg;
    ca = -1; da = -1; fg = -1; t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h05;
    for (int k = 0; k < 20 && (ca < 0 || da < 0); k++) begin
      step();
      if (busy && fg < 0) fg = int'(grant_dma);
      if (cpu_ack && ca < 0) begin ca = cyc; cpu_req = 1'b0; chk({name, "_cpu_rd"}, 32'(cpu_rdata), 32'(exp_c)); end
      if (dma_ack && da < 0) begin da = cyc; dma_req = 1'b0; chk({name, "_dma_rd"}, 32'(dma_rdata), 32'(exp_d)); end
    end
    chk({name, "_first_grant"}, 32'(fg), 32'd0);
    chk({name, "_cpu_lat"}, 32'(ca - t0), 32'd3);
    chk({name, "_dma_gap"}, 32'(da - ca), 32'd4);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int acks, last_ack;
    logic [7:0] order [8];
    cyc = 0; errors = 0; checks = 0;
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0; ram_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'(i * 16'h0101) ^ 16'h5A3C;
      shadow[i] = mem[i];
    end
    mem[8'h10] = 16'hBEEF; shadow[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'hAAAA; shadow[8'h20] = 16'hAAAA;

    tbl[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 8'h05, 16'h1234, 16'hBEEF, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 8'h05, 16'h0000, 16'h1234, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'hAAAA, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 8'h20, 16'h5555, 16'hAAAA, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'hAAAA, 16'h5555};
    tbl[6] = '{1'b1, 1'b0, 8'h05, 16'h0000, 16'hAAAA, 16'h1234};

    tick(); tick();
    model_reset();
    rst = 1'b0;
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant_dma", 32'(grant_dma), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    do_reset();
    sim_pair("tie_after_reset", 16'hBEEF, 16'h1234);

    // Both ports hold req continuously for eight transactions.
    do_reset();
    acks = 0; last_ack = -1;
    cpu_req = 1'b1; dma_req = 1'b1; new_pay(1'b0); new_pay(1'b1);
    for (int k = 0; k < 80 && (cpu_req || dma_req); k++) begin
      step();
      if (cpu_ack || dma_ack) begin
        if (acks < 8) begin
          order[acks] = dma_ack ? 8'h44 : 8'h43;
          if (acks > 0) chk("rr_spacing", 32'(cyc - last_ack), 32'd4);
          last_ack = cyc;
          acks++;
        end
        if (cpu_ack) begin if (acks < 8) new_pay(1'b0); else cpu_req = 1'b0; end
        if (dma_ack) begin if (acks < 8) new_pay(1'b1); else dma_req = 1'b0; end
      end
    end
    chk("rr_ack_count", 32'(acks), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_order%0d", i), 32'(order[i]), (i % 2 == 0) ? 32'h43 : 32'h44);
    step();

    // Reset during WAIT of a DMA read: no ack, back to reset values.
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h10;
    step(); step();
    rst = 1'b1; dma_req = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_wait_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_wait_busy", 32'(busy), 32'd0);
    chk("rst_wait_dma_rdata", 32'(dma_rdata), 32'd0);
    chk("rst_wait_ram_addr", 32'(ram_addr), 32'd0);
    sim_pair("tie_after_abort", 16'hBEEF, 16'h1234);

    // Reset on the edge ending a write's ISSUE cycle: the write still lands.
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h30; dma_wdata = 16'h7777;
    step();
    rst = 1'b1; dma_req = 1'b0;
    step();
    rst = 1'b0;
    run_vec('{1'b0, 1'b0, 8'h30, 16'h0000, 16'h7777, 16'h0000}, "rst_issue_write");

    // Randomized requesters against the reference model.
    for (int k = 0; k < 1500; k++) begin
      if (cpu_req) begin
        if (e_ackc) begin if ($urandom_range(1) == 1) new_pay(1'b0); else cpu_req = 1'b0; end
      end else if ($urandom_range(2) == 0) begin
        cpu_req = 1'b1; new_pay(1'b0);
      end
      if (dma_req) begin
        if (e_ackd) begin if ($urandom_range(1) == 1) new_pay(1'b1); else dma_req = 1'b0; end
      end else if ($urandom_range(2) == 0) begin
        dma_req = 1'b1; new_pay(1'b1);
      end
      step();
    end
    for (int k = 0; k < 40 && (cpu_req || dma_req); k++) begin
      if (e_ackc) cpu_req = 1'b0;
      if (e_ackd) dma_req = 1'b0;
      if (cpu_req || dma_req) step();
    end
    chk("drain_idle", 32'(cpu_req | dma_req), 32'd0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
